hex_scroll_ctrl: RTL and testbench

- Hardware message scroller that owns the six on-board seven-segment displays (HEX5..HEX0).
- Sits between the Nios II PIO conduits and the display pins.
- Firmware writes a message of up to 16 characters into an internal buffer, sets a rate and mode, and pulses start.
- The block then scrolls the message right-to-left across the displays without further CPU involvement, in one-shot or continuous loop mode.

---
 rtl/hex_scroll_pkg.sv | 59 +++++
 rtl/hex7seg_dec.sv | 19 +
 rtl/hex_scroll_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scroll_pkg.sv
// Shared definitions for the hex message scroller.
// Holds the character-code width and blank code, the active-low seven-segment
// patterns for the hex digits and the blank display, the FSM state encoding,
// and a helper that maps a hex digit to its segment pattern.
package hex_scroll_pkg;

    localparam int unsigned CHAR_W = 5;

    // Bit 4 set marks a blank character. The low nibble is then ignored.
    localparam logic [CHAR_W-1:0] CHAR_BLANK = 5'h10;

    // Active-low segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Character-to-segment decoder, purely combinational.
// Ports:
//   char_code  in  5  [4]=1 blank, else [3:0] hex digit
//   seg        out 7  active-low segments, bit0=a ... bit6=g
module hex7seg_dec
    import hex_scroll_pkg::*;
(
    input  logic [CHAR_W-1:0] char_code,
    output logic [6:0]        seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!char_code[CHAR_W-1]) begin
            seg = seg_of_digit(char_code[3:0]);
        end
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Hardware message scroller driving the six seven-segment displays.
// Firmware loads up to 16 characters into the message buffer, sets length,
// rate and mode, then pulses start. The message scrolls right-to-left through
// a virtual sequence of 6 blanks, the message, then the window running off.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   wr_en      in   buffer write strobe
//   wr_addr    in   buffer index
//   wr_data    in   character code ([4]=blank, [3:0]=hex digit)
//   msg_len    in   message length, 0 = empty, values above 16 clamp to 16
//   step_div   in   clocks per scroll step, 0 acts as 1
//   mode       in   0 one-shot, 1 continuous loop
//   start      in   single-cycle start request
//   stop       in   single-cycle abort request
//   busy       out  high while scrolling
//   done       out  one-cycle pulse when a one-shot scroll completes
//   hex0..hex5 out  registered active-low segment patterns
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 16,
    parameter int unsigned DIV_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [4:0]       wr_data,
    input  logic [4:0]       msg_len,
    input  logic [DIV_W-1:0] step_div,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);

    localparam logic [4:0] LEN_MAX = 5'(BUF_DEPTH);

    state_t            state_q, state_d;
    logic [4:0]        pos_q, pos_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              done_q, done_d;

    logic [4:0]        len_c;
    logic [DIV_W-1:0]  div_max;
    logic              step_now;
    logic              seq_end;

    logic [CHAR_W-1:0] buf_mem [BUF_DEPTH];
    logic [5:0]        idx_c   [6];
    logic [5:0]        rel_c   [6];
    logic [CHAR_W-1:0] char_c  [6];
    logic [6:0]        seg_c   [6];
    logic [6:0]        seg_q   [6];

    // Live-sampled controls
    assign len_c   = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
    assign div_max = (step_div == '0) ? '0 : step_div - DIV_W'(1);

    // >= rather than == so a rate reduced mid-scroll steps at once instead of
    // waiting for the counter to wrap.
    assign step_now = (div_q >= div_max);

    // >= so a length shortened below the current window ends/wraps on the
    // next step.
    assign seq_end = (({1'b0, pos_q} + 6'd1) >= ({1'b0, len_c} + 6'd6));

    // Message buffer: writable in any state, read live by the display path
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= CHAR_BLANK;
            end
        end else if (wr_en) begin
            buf_mem[wr_addr] <= wr_data;
        end
    end

    // FSM and counter state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        div_d   = div_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pos_d = '0;
                div_d = '0;
                if (start && !stop && (len_c != '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    pos_d   = '0;
                    div_d   = '0;
                end else if (step_now) begin
                    div_d = '0;
                    if (seq_end) begin
                        pos_d = '0;
                        if (!mode) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pos_d = pos_q + 5'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pos_d   = '0;
                div_d   = '0;
            end
        endcase
    end

    // Window selection: digit k from the left (HEX5 is k=0) shows s[pos+k],
    // where s is 6 leading blanks, the message, then blanks.
    always_comb begin
        for (int unsigned k = 0; k < 6; k++) begin
            idx_c[k]      = {1'b0, pos_q} + 6'(k);
            rel_c[k]      = idx_c[k] - 6'd6;
            char_c[5 - k] = CHAR_BLANK;
            if ((state_q == ST_RUN) && (idx_c[k] >= 6'd6) &&
                (rel_c[k] < {1'b0, len_c})) begin
                char_c[5 - k] = buf_mem[rel_c[k][3:0]];
            end
        end
    end

    for (genvar g = 0; g < 6; g++) begin : gen_dec
        hex7seg_dec u_dec (
            .char_code (char_c[g]),
            .seg       (seg_c[g])
        );
    end

    // Registered segment outputs, one cycle behind the window position
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 6; i++) begin
                seg_q[i] <= SEG_BLANK;
            end
        end else begin
            for (int unsigned i = 0; i < 6; i++) begin
                seg_q[i] <= seg_c[i];
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign hex0 = seg_q[0];
    assign hex1 = seg_q[1];
    assign hex2 = seg_q[2];
    assign hex3 = seg_q[3];
    assign hex4 = seg_q[4];
    assign hex5 = seg_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl. Stimulus pushes cycle-tagged
// expectations into a queue; a monitor on the falling edge pops and compares
// every expectation due at the current cycle.
module tb_hex_scroll_ctrl;

    localparam int SEL_BUSY = 6;
    localparam int SEL_DONE = 7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [4:0]  wr_data;
    logic [4:0]  msg_len;
    logic [31:0] step_div;
    logic        mode;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    hex_scroll_ctrl #(.BUF_DEPTH(16), .DIV_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .msg_len  (msg_len),
        .step_div (step_div),
        .mode     (mode),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex4     (hex4),
        .hex5     (hex5)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        int         sel;
        logic [6:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void expect_at(input int at, input int sel,
                                      input logic [6:0] val, input string name);
        exp_t e;
        int   i;
        e.at = at; e.sel = sel; e.val = val; e.name = name;
        i = 0;
        while (i < exp_q.size() && exp_q[i].at <= at) i++;
        exp_q.insert(i, e);
    endfunction

    function automatic logic [6:0] observe(input int sel);
        case (sel)
            0:        return hex0;
            1:        return hex1;
            2:        return hex2;
            3:        return hex3;
            4:        return hex4;
            5:        return hex5;
            SEL_BUSY: return {6'b0, busy};
            default:  return {6'b0, done};
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] got;
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.at < cyc) begin
                errors++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.at, cyc);
            end else begin
                got = observe(e.sel);
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %02h expected %02h", e.name, cyc, got, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [4:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; step_div = '0; mode = 1'b0; start = 1'b0; stop = 1'b0;

        // Reset state
        expect_at(1, 0, 7'h7F, "rst_hex0");
        expect_at(1, 5, 7'h7F, "rst_hex5");
        expect_at(1, SEL_BUSY, 7'h00, "rst_busy");
        expect_at(1, SEL_DONE, 7'h00, "rst_done");
        go_to(2);
        reset_n = 1'b1;

        // One-shot: buf0=1 buf1=2, L=2, D=4
        wr(4'd0, 5'h01);
        wr(4'd1, 5'h02);
        msg_len = 5'd2; step_div = 32'd4; mode = 1'b0;
        t = cyc + 1;
        expect_at(t,      SEL_BUSY, 7'h01, "os_busy_start");
        expect_at(t + 4,  0, 7'h7F, "os_hex0_pre");
        expect_at(t + 5,  0, 7'h79, "os_hex0_step1");
        expect_at(t + 9,  1, 7'h79, "os_hex1_step2");
        expect_at(t + 9,  0, 7'h24, "os_hex0_step2");
        expect_at(t + 31, SEL_DONE, 7'h00, "os_done_early");
        expect_at(t + 31, SEL_BUSY, 7'h01, "os_busy_late");
        expect_at(t + 32, SEL_DONE, 7'h01, "os_done");
        expect_at(t + 32, SEL_BUSY, 7'h00, "os_busy_end");
        expect_at(t + 33, SEL_DONE, 7'h00, "os_done_pulse");
        expect_at(t + 33, 0, 7'h7F, "os_hex0_blank");
        start = 1'b1; tick(); start = 1'b0;
        go_to(t + 34);

        // Start during RUN ignored, live write on HEX3, stop mid-run
        t = cyc + 1;
        expect_at(t + 5,  0, 7'h79, "col_hex0_step1");
        expect_at(t + 9,  0, 7'h24, "col_restart_ignored");
        expect_at(t + 17, 3, 7'h79, "col_hex3_old");
        expect_at(t + 18, 3, 7'h0E, "col_hex3_new");
        expect_at(t + 18, 2, 7'h24, "col_hex2");
        expect_at(t + 19, SEL_BUSY, 7'h01, "stop_busy_pre");
        expect_at(t + 20, SEL_BUSY, 7'h00, "stop_busy");
        expect_at(t + 20, SEL_DONE, 7'h00, "stop_no_done");
        expect_at(t + 20, 3, 7'h0E, "stop_hex3_hold");
        expect_at(t + 21, 3, 7'h7F, "stop_hex3_blank");
        expect_at(t + 21, SEL_DONE, 7'h00, "stop_no_done2");
        start = 1'b1; tick(); start = 1'b0;
        go_to(t + 5);  start = 1'b1; tick(); start = 1'b0;
        go_to(t + 16); wr(4'd0, 5'h0F);
        go_to(t + 19); stop = 1'b1; tick(); stop = 1'b0;
        go_to(t + 23);

        // Loop mode, step_div=0 acting as 1, L=1, buf0=A
        wr(4'd0, 5'h0A);
        msg_len = 5'd1; step_div = 32'd0; mode = 1'b1;
        t = cyc + 1;
        expect_at(t, SEL_BUSY, 7'h01, "loop_busy");
        for (int c = 1; c <= 16; c++) begin
            expect_at(t + c, 0, ((c % 7) == 2) ? 7'h08 : 7'h7F, "loop_hex0");
        end
        for (int c = 0; c <= 21; c++) begin
            expect_at(t + c, SEL_DONE, 7'h00, "loop_no_done");
        end
        expect_at(t + 19, SEL_BUSY, 7'h01, "loop_busy_pre");
        expect_at(t + 20, SEL_BUSY, 7'h00, "loop_stop_busy");
        expect_at(t + 21, 0, 7'h7F, "loop_stop_blank");
        start = 1'b1; tick(); start = 1'b0;
        go_to(t + 19); stop = 1'b1; tick(); stop = 1'b0;
        go_to(t + 23);

        // msg_len=0 start ignored
        msg_len = 5'd0; mode = 1'b0;
        t = cyc + 1;
        expect_at(t,     SEL_BUSY, 7'h00, "len0_busy");
        expect_at(t + 1, SEL_BUSY, 7'h00, "len0_busy2");
        expect_at(t + 1, SEL_DONE, 7'h00, "len0_done");
        start = 1'b1; tick(); start = 1'b0;
        go_to(t + 3);

        // start+stop together in IDLE: stop wins
        msg_len = 5'd2;
        t = cyc + 1;
        expect_at(t,     SEL_BUSY, 7'h00, "ss_busy");
        expect_at(t + 2, SEL_BUSY, 7'h00, "ss_busy2");
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        go_to(t + 3);

        // msg_len=20 clamps to 16, D=1
        msg_len = 5'd20; step_div = 32'd1; mode = 1'b0;
        t = cyc + 1;
        expect_at(t + 2,  0, 7'h08, "l20_hex0");
        expect_at(t + 21, SEL_DONE, 7'h00, "l20_done_early");
        expect_at(t + 21, SEL_BUSY, 7'h01, "l20_busy");
        expect_at(t + 22, SEL_DONE, 7'h01, "l20_done");
        expect_at(t + 22, SEL_BUSY, 7'h00, "l20_busy_end");
        expect_at(t + 23, SEL_DONE, 7'h00, "l20_done_pulse");
        start = 1'b1; tick(); start = 1'b0;
        go_to(t + 24);

        // Asynchronous reset mid-RUN, then normal operation with cleared buffer
        msg_len = 5'd2; step_div = 32'd4; mode = 1'b0;
        t = cyc + 1;
        expect_at(t + 9,  0, 7'h24, "ar_hex0_pre");
        expect_at(t + 9,  1, 7'h08, "ar_hex1_pre");
        expect_at(t + 10, 0, 7'h7F, "ar_hex0");
        expect_at(t + 10, 1, 7'h7F, "ar_hex1");
        expect_at(t + 10, SEL_BUSY, 7'h00, "ar_busy");
        expect_at(t + 10, SEL_DONE, 7'h00, "ar_done");
        expect_at(t + 12, SEL_BUSY, 7'h00, "ar_busy_rel");
        start = 1'b1; tick(); start = 1'b0;
        go_to(t + 10); reset_n = 1'b0;
        go_to(t + 12); reset_n = 1'b1;
        wr(4'd0, 5'h03);
        step_div = 32'd1;
        t = cyc + 1;
        expect_at(t,     SEL_BUSY, 7'h01, "ar2_busy");
        expect_at(t + 2, 0, 7'h30, "ar2_hex0");
        expect_at(t + 3, 0, 7'h7F, "ar2_buf1_cleared");
        expect_at(t + 3, 1, 7'h30, "ar2_hex1");
        expect_at(t + 8, SEL_DONE, 7'h01, "ar2_done");
        expect_at(t + 8, SEL_BUSY, 7'h00, "ar2_busy_end");
        start = 1'b1; tick(); start = 1'b0;
        go_to(t + 10);

        go_to(cyc + 2);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: check for cycle %0d never reached", e.name, e.at);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
